// File: rtl/wb_load_store_master.sv
// Single-outstanding Wishbone classic master for the core load/store port.
// One request -> one bus cycle -> one-cycle response pulse, followed by a
// mandatory idle cycle so a slave that holds its read ack can release it.
module wb_load_store_master #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    // core request / response
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_adr_i,
    input  logic [DW-1:0] req_dat_i,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_dat_o,
    output logic          rsp_err_o,
    // Wishbone master
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [AW-1:0] adr_o,
    output logic [DW-1:0] dat_o,
    input  logic          ack_i,
    input  logic [DW-1:0] dat_i
);

    localparam int unsigned WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
    logic            rsp_err_q, rsp_err_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic            timeout;

    // Watchdog has reached its last permitted cycle without an ack
    assign timeout = (wd_q == WDW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ack takes priority over the watchdog
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i)       state_d = BUS;
            BUS:     if (ack_i || timeout)  state_d = GAP;
            GAP:                            state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs
    always_comb begin
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        wd_d        = wd_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    cyc_d = 1'b1;
                    we_d  = req_we_i;
                    adr_d = req_adr_i;
                    dat_d = req_dat_i;
                    wd_d  = '0;
                end
            end
            BUS: begin
                if (ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? dat_q : dat_i;
                end else if (timeout) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            default: ;
        endcase
    end

    // Output and watchdog registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            wd_q        <= '0;
        end else begin
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            wd_q        <= wd_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign cyc_o       = cyc_q;
    assign stb_o       = cyc_q;
    assign we_o        = we_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_load_store_master.sv
// Bench for wb_load_store_master: 8-bit data memory slave model, scoreboard
// of expected responses checked by an independent monitor, directed cases
// followed by randomized traffic.
module tb_wb_load_store_master;

    localparam int unsigned AW      = 8;
    localparam int unsigned DW      = 8;
    localparam int unsigned TIMEOUT = 8;

    logic          clk_i;
    logic          rst_ni;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [AW-1:0] req_adr_i;
    logic [DW-1:0] req_dat_i;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_err_o;
    logic          cyc_o;
    logic          stb_o;
    logic          we_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic          ack_i;
    logic [DW-1:0] dat_i;

    wb_load_store_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_adr_i   (req_adr_i),
        .req_dat_i   (req_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .ack_i       (ack_i),
        .dat_i       (dat_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Data memory slave: write acks combinationally, read ack is registered
    // and stays high as long as stb does.
    logic [DW-1:0] smem [256];
    logic          rd_ack_q;
    logic [DW-1:0] rdata_q;
    logic          disconnect;
    logic          force_ack;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rd_ack_q <= 1'b0;
        else         rd_ack_q <= stb_o & ~we_o;
    end

    always @(posedge clk_i) begin
        if (stb_o && !we_o) rdata_q <= smem[adr_o];
        if (stb_o && we_o && ack_i) smem[adr_o] <= dat_o;
    end

    assign ack_i = force_ack | (((stb_o & we_o) | rd_ack_q) & ~disconnect);
    assign dat_i = rdata_q;

    // Reference model: plain memory image plus expected-response queue
    typedef struct packed {
        logic [DW-1:0] dat;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] model [256];
    logic [AW-1:0] written[$];
    int            vectors;
    int            miscompares;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.dat = d;
        x.err = e;
        exp_q.push_back(x);
    endtask

    // Monitor: every response pulse must match the oldest expectation
    always @(negedge clk_i) begin
        if (rst_ni && rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rsp: got dat 0x%0h err %0d, expected no response",
                         rsp_dat_o, rsp_err_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_dat", int'(rsp_dat_o), int'(mon_e.dat));
                check("rsp_err", int'(rsp_err_o), int'(mon_e.err));
            end
        end
    end

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        @(negedge clk_i);
        while (!req_ready_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        check({name, "_ready"}, int'(req_ready_o), 1);
    endtask

    // One transaction. mode 0: normal slave, 1: slave disconnected,
    // 2: slave disconnected but ack forced on the watchdog's final cycle.
    task automatic txn(input string name, input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input int mode);
        int len, stb_len, rsp_k, rdy_k, bad;
        len = (mode != 0) ? int'(TIMEOUT) : (we ? 1 : 2);
        wait_ready(name);
        disconnect  = (mode != 0);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_adr_i   = adr;
        req_dat_i   = dat;
        if (mode == 1) begin
            push_exp('0, 1'b1);
        end else if (we) begin
            push_exp(dat, 1'b0);
            model[adr] = dat;
            written.push_back(adr);
        end else begin
            push_exp(model[adr], 1'b0);
        end
        @(posedge clk_i);
        stb_len = -1; rsp_k = -1; rdy_k = -1; bad = 0;
        for (int k = 0; k < int'(TIMEOUT) + 4; k++) begin
            @(negedge clk_i);
            if (k == 0) begin
                req_valid_i = 1'b0;
                req_we_i    = 1'($urandom);
                req_adr_i   = AW'($urandom);
                req_dat_i   = DW'($urandom);
            end
            force_ack = (mode == 2) && (k == int'(TIMEOUT) - 1);
            if (stb_o && (adr_o !== adr || we_o !== we || (we && dat_o !== dat))) bad++;
            if (stb_o !== cyc_o) bad++;
            if (!stb_o && stb_len < 0) stb_len = k;
            if (rsp_valid_o && rsp_k < 0) rsp_k = k;
            if (req_ready_o && rdy_k < 0) rdy_k = k;
        end
        force_ack  = 1'b0;
        disconnect = 1'b0;
        check({name, "_stb_len"}, stb_len, len);
        check({name, "_rsp_cycle"}, rsp_k, len);
        check({name, "_ready_cycle"}, rdy_k, len + 1);
        check({name, "_bus_hold"}, bad, 0);
    endtask

    initial begin
        int low, second;
        logic [AW-1:0] a2;
        logic [AW-1:0] ra;
        logic          rwe;
        int            r, m;

        vectors     = 0;
        miscompares = 0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_adr_i   = '0;
        req_dat_i   = '0;
        disconnect  = 1'b0;
        force_ack   = 1'b0;
        rst_ni      = 1'b1;
        #1 rst_ni   = 1'b0;
        #12;
        check("reset_cyc", int'(cyc_o), 0);
        check("reset_stb", int'(stb_o), 0);
        check("reset_we_adr_dat", int'({we_o, adr_o, dat_o}), 0);
        check("reset_rsp", int'({rsp_valid_o, rsp_err_o, rsp_dat_o}), 0);
        check("reset_ready", int'(req_ready_o), 1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Store then load through a working slave
        txn("store_10", 1'b1, 8'h10, 8'hA5, 0);
        check("mem_10", int'(smem[8'h10]), 8'hA5);
        txn("store_11", 1'b1, 8'h11, 8'h3C, 0);
        txn("load_10", 1'b0, 8'h10, 8'h00, 0);

        // Back-to-back loads with req_valid held high
        wait_ready("b2b");
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_adr_i   = 8'h10;
        push_exp(8'hA5, 1'b0);
        @(posedge clk_i);
        low = 0; second = -1; a2 = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            if (k == 0) begin
                req_adr_i = 8'h11;
                push_exp(8'h3C, 1'b0);
            end
            if (k == 4) req_valid_i = 1'b0;
            if (!stb_o && second < 0) low++;
            if (stb_o && low > 0 && second < 0) begin
                second = k;
                a2     = adr_o;
            end
        end
        // stb low for the GAP cycle plus the IDLE cycle that accepts
        check("b2b_low_cycles", low, 2);
        check("b2b_second_start", second, 4);
        check("b2b_second_adr", int'(a2), 8'h11);

        // Slave disconnected: watchdog ends the cycle with an error
        txn("timeout_load", 1'b0, 8'h10, 8'h00, 1);
        txn("timeout_store", 1'b1, 8'h12, 8'h77, 1);

        // Reset during the first BUS cycle of a load drops it silently
        wait_ready("rst");
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_adr_i   = 8'h10;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("rst_pre_cyc", int'(cyc_o), 1);
        rst_ni = 1'b0;
        #1;
        check("rst_cyc_drop", int'(cyc_o), 0);
        check("rst_stb_drop", int'(stb_o), 0);
        check("rst_no_rsp", int'(rsp_valid_o), 0);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_ready_after", int'(req_ready_o), 1);
        repeat (3) @(negedge clk_i);
        txn("post_rst_store", 1'b1, 8'h20, 8'h5A, 0);

        // Ack arriving together with the timeout wins
        txn("ack_at_timeout_load", 1'b0, 8'h11, 8'h00, 2);
        txn("ack_at_timeout_store", 1'b1, 8'h13, 8'hC3, 2);
        check("mem_13", int'(smem[8'h13]), 8'hC3);

        // Randomized traffic against the memory model
        for (int i = 0; i < 40; i++) begin
            r   = int'($urandom_range(0, 9));
            m   = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
            rwe = 1'($urandom_range(0, 1));
            if (rwe) ra = AW'($urandom);
            else     ra = written[$urandom_range(0, written.size() - 1)];
            txn("rand", rwe, ra, DW'($urandom), m);
        end

        repeat (4) @(negedge clk_i);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, expected finish");
        $fatal(1, "timeout");
    end

endmodule
